// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one multi-cycle memory port between the fetch (I) and data (D) sides.
// Each side has a one-deep request slot; one memory transaction is outstanding at a time.
module mem_port_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                imem_req,
  input  logic [ADDR_W-1:0]   imem_addr,
  input  logic [DATA_W/8-1:0] imem_rmask,
  output logic                imem_resp,
  output logic [DATA_W-1:0]   imem_rdata,
  input  logic                dmem_req,
  input  logic [ADDR_W-1:0]   dmem_addr,
  input  logic [DATA_W/8-1:0] dmem_rmask,
  input  logic [DATA_W/8-1:0] dmem_wmask,
  input  logic [DATA_W-1:0]   dmem_wdata,
  output logic                dmem_resp,
  output logic [DATA_W-1:0]   dmem_rdata,
  output logic                mem_req,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W/8-1:0] mem_rmask,
  output logic [DATA_W/8-1:0] mem_wmask,
  output logic [DATA_W-1:0]   mem_wdata,
  input  logic                mem_resp,
  input  logic [DATA_W-1:0]   mem_rdata,
  output logic                proto_err
);

  localparam int MW = DATA_W / 8;
  localparam logic SIDE_I = 1'b0;
  localparam logic SIDE_D = 1'b1;

  typedef enum logic {IDLE = 1'b0, WAIT = 1'b1} state_t;

  state_t            state_r, state_nxt_s;
  logic              owner_r, last_grant_r;
  logic              pend_i_r, pend_d_r;
  logic [ADDR_W-1:0] i_addr_r, d_addr_r;
  logic [MW-1:0]     i_rmask_r, d_rmask_r, d_wmask_r;
  logic [DATA_W-1:0] d_wdata_r;
  logic              mem_req_r;
  logic [ADDR_W-1:0] mem_addr_r;
  logic [MW-1:0]     mem_rmask_r, mem_wmask_r;
  logic [DATA_W-1:0] mem_wdata_r;
  logic              proto_err_r;

  logic              issue_s, winner_s, resp_ok_s, owner_pend_s, other_pend_s;
  logic              clear_i_s, clear_d_s, drop_i_s, drop_d_s, spurious_s;
  logic              imem_resp_s, dmem_resp_s;
  logic [DATA_W-1:0] imem_rdata_s, dmem_rdata_s;

  // A response only counts while waiting and while the owner's slot is still outstanding.
  assign owner_pend_s = (owner_r == SIDE_D) ? pend_d_r : pend_i_r;
  assign other_pend_s = (owner_r == SIDE_D) ? pend_i_r : pend_d_r;
  assign resp_ok_s    = (state_r == WAIT) && mem_resp && owner_pend_s;
  assign spurious_s   = mem_resp && !resp_ok_s;
  assign clear_i_s    = resp_ok_s && (owner_r == SIDE_I);
  assign clear_d_s    = resp_ok_s && (owner_r == SIDE_D);
  // Re-request in the owner's own response cycle is legal: the capture replaces the clear.
  assign drop_i_s     = imem_req && pend_i_r && !clear_i_s;
  assign drop_d_s     = dmem_req && pend_d_r && !clear_d_s;

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // FSM next-state and issue/grant decision.
  always_comb begin
    issue_s     = 1'b0;
    winner_s    = SIDE_I;
    state_nxt_s = state_r;
    case (state_r)
      IDLE: begin
        if (pend_i_r || pend_d_r) begin
          issue_s     = 1'b1;
          state_nxt_s = WAIT;
          if (pend_i_r && pend_d_r) begin
            winner_s = ~last_grant_r;
          end else if (pend_d_r) begin
            winner_s = SIDE_D;
          end else begin
            winner_s = SIDE_I;
          end
        end else begin
          state_nxt_s = IDLE;
        end
      end
      WAIT: begin
        if (resp_ok_s) begin
          if (other_pend_s) begin
            issue_s     = 1'b1;
            winner_s    = ~owner_r;
            state_nxt_s = WAIT;
          end else begin
            state_nxt_s = IDLE;
          end
        end else begin
          state_nxt_s = WAIT;
        end
      end
      default: begin
        state_nxt_s = IDLE;
      end
    endcase
  end

  // Response routing: only the owner sees resp, rdata is zero outside resp.
  always_comb begin
    imem_resp_s  = clear_i_s;
    dmem_resp_s  = clear_d_s;
    imem_rdata_s = {DATA_W{1'b0}};
    dmem_rdata_s = {DATA_W{1'b0}};
    if (clear_i_s) begin
      imem_rdata_s = mem_rdata;
    end else begin
      imem_rdata_s = {DATA_W{1'b0}};
    end
    if (clear_d_s) begin
      dmem_rdata_s = mem_rdata;
    end else begin
      dmem_rdata_s = {DATA_W{1'b0}};
    end
  end

  // Fetch request slot.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_i_r  <= 1'b0;
      i_addr_r  <= {ADDR_W{1'b0}};
      i_rmask_r <= {MW{1'b0}};
    end else if (imem_req && !drop_i_s) begin
      pend_i_r  <= 1'b1;
      i_addr_r  <= imem_addr;
      i_rmask_r <= imem_rmask;
    end else if (clear_i_s) begin
      pend_i_r  <= 1'b0;
    end
  end

  // Data request slot.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_d_r  <= 1'b0;
      d_addr_r  <= {ADDR_W{1'b0}};
      d_rmask_r <= {MW{1'b0}};
      d_wmask_r <= {MW{1'b0}};
      d_wdata_r <= {DATA_W{1'b0}};
    end else if (dmem_req && !drop_d_s) begin
      pend_d_r  <= 1'b1;
      d_addr_r  <= dmem_addr;
      d_rmask_r <= dmem_rmask;
      d_wmask_r <= dmem_wmask;
      d_wdata_r <= dmem_wdata;
    end else if (clear_d_s) begin
      pend_d_r  <= 1'b0;
    end
  end

  // Memory-side command registers, held from issue until the response.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_req_r    <= 1'b0;
      mem_addr_r   <= {ADDR_W{1'b0}};
      mem_rmask_r  <= {MW{1'b0}};
      mem_wmask_r  <= {MW{1'b0}};
      mem_wdata_r  <= {DATA_W{1'b0}};
      owner_r      <= SIDE_I;
      last_grant_r <= SIDE_D;
    end else begin
      mem_req_r <= issue_s;
      if (issue_s) begin
        owner_r      <= winner_s;
        last_grant_r <= winner_s;
        if (winner_s == SIDE_D) begin
          mem_addr_r  <= d_addr_r;
          mem_rmask_r <= d_rmask_r;
          mem_wmask_r <= d_wmask_r;
          mem_wdata_r <= d_wdata_r;
        end else begin
          mem_addr_r  <= i_addr_r;
          mem_rmask_r <= i_rmask_r;
          mem_wmask_r <= {MW{1'b0}};
          mem_wdata_r <= {DATA_W{1'b0}};
        end
      end else if (resp_ok_s) begin
        mem_rmask_r <= {MW{1'b0}};
        mem_wmask_r <= {MW{1'b0}};
      end
    end
  end

  // Sticky protocol-violation flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      proto_err_r <= 1'b0;
    end else begin
      proto_err_r <= proto_err_r | drop_i_s | drop_d_s | spurious_s;
    end
  end

  assign imem_resp  = imem_resp_s;
  assign imem_rdata = imem_rdata_s;
  assign dmem_resp  = dmem_resp_s;
  assign dmem_rdata = dmem_rdata_s;
  assign mem_req    = mem_req_r;
  assign mem_addr   = mem_addr_r;
  assign mem_rmask  = mem_rmask_r;
  assign mem_wmask  = mem_wmask_r;
  assign mem_wdata  = mem_wdata_r;
  assign proto_err  = proto_err_r;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: fetch, tie, alternation, store, violations, mid-transaction reset.
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [3:0]  imem_rmask;
  logic        imem_resp;
  logic [31:0] imem_rdata;
  logic        dmem_req;
  logic [31:0] dmem_addr;
  logic [3:0]  dmem_rmask, dmem_wmask;
  logic [31:0] dmem_wdata;
  logic        dmem_resp;
  logic [31:0] dmem_rdata;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic [3:0]  mem_rmask, mem_wmask;
  logic [31:0] mem_wdata;
  logic        mem_resp;
  logic [31:0] mem_rdata;
  logic        proto_err;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_rmask(imem_rmask),
    .imem_resp(imem_resp), .imem_rdata(imem_rdata),
    .dmem_req(dmem_req), .dmem_addr(dmem_addr), .dmem_rmask(dmem_rmask),
    .dmem_wmask(dmem_wmask), .dmem_wdata(dmem_wdata),
    .dmem_resp(dmem_resp), .dmem_rdata(dmem_rdata),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_rmask(mem_rmask),
    .mem_wmask(mem_wmask), .mem_wdata(mem_wdata),
    .mem_resp(mem_resp), .mem_rdata(mem_rdata), .proto_err(proto_err)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    #2 rst_n = 1'b0;
    #2 rst_n = 1'b1;
    tick();
  endtask

  initial begin
    rst_n = 1'b0; imem_req = 1'b0; imem_addr = 32'h0; imem_rmask = 4'h0;
    dmem_req = 1'b0; dmem_addr = 32'h0; dmem_rmask = 4'h0; dmem_wmask = 4'h0;
    dmem_wdata = 32'h0; mem_resp = 1'b0; mem_rdata = 32'h0;
    tick(); tick();
    chk("rst_mem_req", 64'(mem_req), 64'h0);
    chk("rst_mem_addr", 64'(mem_addr), 64'h0);
    chk("rst_mem_rmask", 64'(mem_rmask), 64'h0);
    chk("rst_imem_resp", 64'(imem_resp), 64'h0);
    chk("rst_dmem_rdata", 64'(dmem_rdata), 64'h0);
    chk("rst_proto_err", 64'(proto_err), 64'h0);
    rst_n = 1'b1;
    tick();

    // 1: single fetch, memory answers 3 cycles after mem_req
    imem_req = 1'b1; imem_addr = 32'h1eceb000; imem_rmask = 4'hF;
    tick(); imem_req = 1'b0; imem_addr = 32'h0; imem_rmask = 4'h0;
    chk("t1_no_req_c1", 64'(mem_req), 64'h0);
    tick();
    chk("t1_mem_req_c2", 64'(mem_req), 64'h1);
    chk("t1_addr_c2", 64'(mem_addr), 64'h1eceb000);
    chk("t1_rmask_c2", 64'(mem_rmask), 64'hF);
    tick();
    chk("t1_req_low_c3", 64'(mem_req), 64'h0);
    chk("t1_addr_c3", 64'(mem_addr), 64'h1eceb000);
    tick();
    chk("t1_addr_c4", 64'(mem_addr), 64'h1eceb000);
    tick();
    mem_resp = 1'b1; mem_rdata = 32'hCAFE0001;
    #1;
    chk("t1_imem_resp", 64'(imem_resp), 64'h1);
    chk("t1_imem_rdata", 64'(imem_rdata), 64'hCAFE0001);
    chk("t1_dmem_resp", 64'(dmem_resp), 64'h0);
    tick(); mem_resp = 1'b0; mem_rdata = 32'h0; #1;
    chk("t1_resp_low", 64'(imem_resp), 64'h0);
    chk("t1_rdata_zero", 64'(imem_rdata), 64'h0);
    chk("t1_rmask_clr", 64'(mem_rmask), 64'h0);
    chk("t1_mem_req_idle", 64'(mem_req), 64'h0);

    // 2: same-cycle tie after reset, I first then D with no gap
    do_reset();
    imem_req = 1'b1; imem_addr = 32'h100; imem_rmask = 4'hF;
    dmem_req = 1'b1; dmem_addr = 32'h200; dmem_rmask = 4'hF;
    tick(); imem_req = 1'b0; dmem_req = 1'b0;
    tick();
    chk("t2_first_req", 64'(mem_req), 64'h1);
    chk("t2_first_addr", 64'(mem_addr), 64'h100);
    tick();
    mem_resp = 1'b1; mem_rdata = 32'h11111111; #1;
    chk("t2_i_resp", 64'(imem_resp), 64'h1);
    chk("t2_i_rdata", 64'(imem_rdata), 64'h11111111);
    chk("t2_d_noresp", 64'(dmem_resp), 64'h0);
    tick(); mem_resp = 1'b0; #1;
    chk("t2_second_req", 64'(mem_req), 64'h1);
    chk("t2_second_addr", 64'(mem_addr), 64'h200);
    tick();
    mem_resp = 1'b1; mem_rdata = 32'h22222222; #1;
    chk("t2_d_resp", 64'(dmem_resp), 64'h1);
    chk("t2_d_rdata", 64'(dmem_rdata), 64'h22222222);
    chk("t2_i_noresp", 64'(imem_resp), 64'h0);
    tick(); mem_resp = 1'b0; #1;
    chk("t2_idle_req", 64'(mem_req), 64'h0);
    chk("t2_idle_rmask", 64'(mem_rmask), 64'h0);

    // 3: alternation, each owner re-requests in its own resp cycle
    imem_addr = 32'hA00; dmem_addr = 32'hD00;
    imem_req = 1'b1; dmem_req = 1'b1;
    tick(); imem_req = 1'b0; dmem_req = 1'b0;
    tick();
    for (int t = 0; t < 6; t++) begin
      chk($sformatf("t3_req_%0d", t), 64'(mem_req), 64'h1);
      chk($sformatf("t3_addr_%0d", t), 64'(mem_addr), (t % 2 == 0) ? 64'hA00 : 64'hD00);
      tick();
      mem_resp = 1'b1; mem_rdata = 32'hA0 + 32'(t);
      if (t < 4) begin
        if (t % 2 == 0) imem_req = 1'b1;
        else dmem_req = 1'b1;
      end
      #1;
      if (t % 2 == 0) begin
        chk($sformatf("t3_iresp_%0d", t), 64'(imem_resp), 64'h1);
        chk($sformatf("t3_irdata_%0d", t), 64'(imem_rdata), 64'hA0 + 64'(t));
      end else begin
        chk($sformatf("t3_dresp_%0d", t), 64'(dmem_resp), 64'h1);
        chk($sformatf("t3_drdata_%0d", t), 64'(dmem_rdata), 64'hA0 + 64'(t));
      end
      tick(); mem_resp = 1'b0; imem_req = 1'b0; dmem_req = 1'b0; #1;
    end
    chk("t3_done_idle", 64'(mem_req), 64'h0);
    chk("t3_no_err", 64'(proto_err), 64'h0);

    // 4: store
    dmem_req = 1'b1; dmem_addr = 32'h1000; dmem_rmask = 4'h0;
    dmem_wmask = 4'h3; dmem_wdata = 32'hDEADBEEF;
    tick(); dmem_req = 1'b0; dmem_wdata = 32'h0; dmem_wmask = 4'h0;
    tick();
    chk("t4_req", 64'(mem_req), 64'h1);
    chk("t4_addr", 64'(mem_addr), 64'h1000);
    chk("t4_wmask", 64'(mem_wmask), 64'h3);
    chk("t4_rmask", 64'(mem_rmask), 64'h0);
    chk("t4_wdata", 64'(mem_wdata), 64'hDEADBEEF);
    tick();
    chk("t4_wdata_held", 64'(mem_wdata), 64'hDEADBEEF);
    chk("t4_wmask_held", 64'(mem_wmask), 64'h3);
    mem_resp = 1'b1; mem_rdata = 32'h0; #1;
    chk("t4_dresp", 64'(dmem_resp), 64'h1);
    tick(); mem_resp = 1'b0; #1;
    chk("t4_dresp_1cyc", 64'(dmem_resp), 64'h0);
    chk("t4_wmask_clr", 64'(mem_wmask), 64'h0);

    // 5a: second fetch request while the first is outstanding
    imem_req = 1'b1; imem_addr = 32'h300; imem_rmask = 4'hF;
    tick(); imem_addr = 32'h400;
    tick(); imem_req = 1'b0;
    chk("t5_req_first", 64'(mem_req), 64'h1);
    chk("t5_addr_first", 64'(mem_addr), 64'h300);
    chk("t5_err_drop", 64'(proto_err), 64'h1);
    tick();
    mem_resp = 1'b1; #1;
    chk("t5_iresp", 64'(imem_resp), 64'h1);
    tick(); mem_resp = 1'b0;
    tick();
    chk("t5_not_issued", 64'(mem_req), 64'h0);
    chk("t5_err_sticky", 64'(proto_err), 64'h1);

    // 5b: response while idle
    do_reset();
    chk("t5_err_cleared", 64'(proto_err), 64'h0);
    mem_resp = 1'b1; #1;
    chk("t5_idle_iresp", 64'(imem_resp), 64'h0);
    chk("t5_idle_dresp", 64'(dmem_resp), 64'h0);
    tick(); mem_resp = 1'b0;
    chk("t5_idle_err", 64'(proto_err), 64'h1);
    tick(); tick();
    chk("t5_idle_sticky", 64'(proto_err), 64'h1);

    // 6: asynchronous reset while waiting
    do_reset();
    imem_req = 1'b1; imem_addr = 32'h500; imem_rmask = 4'hF;
    tick(); imem_req = 1'b0;
    tick();
    chk("t6_req_before", 64'(mem_req), 64'h1);
    #2 rst_n = 1'b0; #1;
    chk("t6_req_async", 64'(mem_req), 64'h0);
    chk("t6_addr_async", 64'(mem_addr), 64'h0);
    chk("t6_rmask_async", 64'(mem_rmask), 64'h0);
    #1 rst_n = 1'b1;
    tick();
    mem_resp = 1'b1; #1;
    chk("t6_late_iresp", 64'(imem_resp), 64'h0);
    chk("t6_late_rdata", 64'(imem_rdata), 64'h0);
    tick(); mem_resp = 1'b0;
    chk("t6_late_err", 64'(proto_err), 64'h1);
    chk("t6_no_issue", 64'(mem_req), 64'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
